// File: rtl/ps2_pkg.sv
// Shared types and helpers for the device-side PS/2 keyboard transmitter.
package ps2_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLDOFF = 3'd1,
    SETUP   = 3'd2,
    LOW     = 3'd3,
    HIGH    = 3'd4
  } ps2_state_e;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;

  // Index of the stop bit, the last bit clocked out in a frame.
  localparam logic [3:0] PS2_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  // Odd parity: 1 when the byte carries an even number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Frame in transmit order, bit 0 first: start, d0..d7, parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
    return {1'b1, ps2_odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Scan-code buffer: synchronous FIFO whose head can be peeked without popping,
// so an aborted frame can resend the same byte.
module ps2_tx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit; they run modulo 2*DEPTH.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        push_s;
  logic        pop_s;

  // Occupancy flags and pointer advance; a write while full is dropped
  // even if a pop happens in the same cycle.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_s   = wr_en && !full;
    pop_s    = rd_pop && !empty;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset discards all buffered bytes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: buffers scan codes and clocks each one out as
// an 11-bit frame, backing off whenever the host holds the clock line low.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int PS2DIV     = 1500,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_wr,
  output logic       fifo_full,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data,
  input  logic       ps2_clk_in
);

  localparam int CW = $clog2(2 * PS2DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(PS2DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(2 * PS2DIV - 1);

  ps2_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      clk_meta_q, clk_meta_d;
  logic                      clk_s_q, clk_s_d;
  logic                      ps2_clk_q, ps2_clk_d;
  logic                      ps2_data_q, ps2_data_d;
  logic                      busy_q, busy_d;
  logic                      half_done_s;
  logic                      pop_s;
  logic                      fifo_empty_s;
  logic                      fifo_full_s;
  logic [7:0]                head_s;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_data (byte_in),
    .wr_en   (byte_wr),
    .rd_pop  (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign fifo_full = fifo_full_s;
  assign busy      = busy_q;
  assign ps2_clk   = ps2_clk_q;
  assign ps2_data  = ps2_data_q;

  // Next-state logic for the frame sequencer and the bus-clock synchroniser.
  // The synchroniser only sees a released line two cycles into a HIGH phase,
  // so a loopback bus needs at least three cycles per half-period to avoid
  // reading its own LOW phase as host inhibit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    ps2_clk_d   = ps2_clk_q;
    ps2_data_d  = ps2_data_q;
    busy_d      = busy_q;
    pop_s       = 1'b0;
    clk_meta_d  = ps2_clk_in;
    clk_s_d     = clk_meta_q;
    half_done_s = (cnt_q == HALF_LAST);

    case (state_q)
      IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        busy_d     = 1'b0;
        cnt_d      = '0;
        idx_d      = 4'd0;
        if (!fifo_empty_s) begin
          state_d = HOLDOFF;
        end else begin
          state_d = IDLE;
        end
      end

      HOLDOFF: begin
        if (!clk_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Head byte is only peeked here; it leaves the FIFO after the stop bit.
          frame_d    = ps2_build_frame(head_s);
          ps2_data_d = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SETUP: begin
        if (half_done_s) begin
          cnt_d     = '0;
          idx_d     = 4'd0;
          ps2_clk_d = 1'b0;
          state_d   = LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      LOW: begin
        // No inhibit check here: the line is low because we drive it.
        if (half_done_s) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          frame_d   = {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
          if (idx_q == PS2_LAST_BIT) begin
            ps2_data_d = 1'b1;
          end else begin
            ps2_data_d = frame_q[1];
          end
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HIGH: begin
        if (half_done_s) begin
          cnt_d = '0;
          if (idx_q == PS2_LAST_BIT) begin
            // Stop bit done: the byte is delivered even if the host inhibits now.
            pop_s      = 1'b1;
            busy_d     = 1'b0;
            ps2_data_d = 1'b1;
            state_d    = IDLE;
          end else if (!clk_s_q) begin
            // Host inhibit: abandon the frame, keep the byte for a resend.
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            idx_d     = idx_q + 4'd1;
            ps2_clk_d = 1'b0;
            state_d   = LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        busy_d     = 1'b0;
        cnt_d      = '0;
        idx_d      = 4'd0;
        state_d    = IDLE;
      end
    endcase
  end

  // Sequencer state and registered bus outputs; reset releases both lines at once.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      frame_q    <= '1;
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      clk_meta_q <= clk_meta_d;
      clk_s_q    <= clk_s_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed + randomized bench for ps2_kbd_tx with a loopback PS/2 host.
module tb_ps2_kbd_tx;

  localparam int DIV       = 4;
  localparam int DEPTH     = 16;
  localparam int FRAME_CYC = 23 * DIV;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] byte_in  = 8'h00;
  logic       byte_wr  = 1'b0;
  logic       host_clk = 1'b1;
  logic       fifo_full, busy, ps2_clk, ps2_data, ps2_clk_in;

  assign ps2_clk_in = ps2_clk & host_clk;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_tx #(.PS2DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_wr    (byte_wr),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_in (ps2_clk_in)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [10:0] rx_q[$];
  logic [7:0]  exp_q[$];

  // Host-side monitor state.
  int          mon_bits = 0, busy_len = 0, last_busy_len = 0;
  int          idle_run = 0, last_gap = 0, starts = 0, aborts = 0;
  logic [10:0] cur_frame = '0;
  logic        prev_clk = 1'b1, prev_busy = 1'b0;

  // Reference frame from the protocol rules: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk_sys);
    byte_in = b;
    byte_wr = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    @(negedge clk_sys);
    byte_wr = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk_sys);
      t++;
    end
    check(tag, (rx_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk_sys);
      t++;
    end
    check(tag, busy, 0);
  endtask

  task automatic expect_frame(input string tag);
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      logic [7:0] b;
      b = exp_q.pop_front();
      check(tag, rx_q.pop_front(), model_frame(b));
    end
  endtask

  // Host monitor: samples the bus 2 time units after each rising edge,
  // captures data at every clock fall and times busy and idle stretches.
  always begin
    @(posedge clk_sys);
    #2;
    if (reset) begin
      mon_bits  = 0;
      busy_len  = 0;
      idle_run  = 0;
      prev_clk  = 1'b1;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        starts++;
        last_gap  = idle_run;
        mon_bits  = 0;
        busy_len  = 0;
        cur_frame = '0;
      end
      if (busy) busy_len++;
      if (!busy && prev_busy) begin
        last_busy_len = busy_len;
        if (mon_bits < 11) aborts++;
        idle_run = 0;
      end
      if (!busy && ps2_clk && ps2_data) idle_run++;
      if (prev_clk && !ps2_clk && mon_bits < 11) begin
        cur_frame[mon_bits] = ps2_data;
        mon_bits++;
        if (mon_bits == 11) rx_q.push_back(cur_frame);
      end
      prev_clk  = ps2_clk;
      prev_busy = busy;
    end
  end

  initial begin
    int          t;
    int          ab0;
    int          st0;
    logic [7:0]  b;
    logic [10:0] lit;

    // Reset state.
    cycles(3);
    check("rst_clk", ps2_clk, 1);
    check("rst_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_full", fifo_full, 0);
    reset = 1'b0;
    cycles(30);
    check("idle_no_start", starts, 0);

    // Single byte 0x1C: one idle cycle then 2*DIV holdoff before busy rises.
    write_byte(8'h1C);
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    check("holdoff_latency", t, 2 * DIV + 1);
    wait_rx(1, 200, "rx_1c_timeout");
    wait_idle(50, "idle_1c_timeout");
    lit = {1'b1, 1'b0, 8'h1C, 1'b0};
    check("frame_1c_literal", rx_q[0], lit);
    expect_frame("frame_1c");
    check("busy_len_1c", last_busy_len, FRAME_CYC);

    // 0x00 then 0xFF: both parity bits 1, stop bits 1, holdoff gap between.
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_rx(2, 400, "rx_00ff_timeout");
    wait_idle(50, "idle_00ff_timeout");
    check("par_00", rx_q[0][9], 1);
    check("par_ff", rx_q[1][9], 1);
    check("stop_00", rx_q[0][10], 1);
    check("stop_ff", rx_q[1][10], 1);
    check("gap_ge_holdoff", (last_gap >= 2 * DIV), 1);
    expect_frame("frame_00");
    expect_frame("frame_ff");

    // Random bytes with random spacing.
    for (int i = 0; i < 6; i++) begin
      write_byte(8'($urandom));
      cycles($urandom_range(0, 3));
    end
    wait_rx(6, 1500, "rx_rand_timeout");
    wait_idle(50, "idle_rand_timeout");
    for (int i = 0; i < 6; i++) expect_frame("frame_rand");

    // Inhibit during the HIGH phase after d3 of 0xF0: abort, then full resend.
    ab0 = aborts;
    write_byte(8'hF0);
    t = 0;
    while (!(mon_bits == 5 && ps2_clk && busy) && t < 300) begin
      @(negedge clk_sys);
      t++;
    end
    check("abort_reach_d3_high", (t < 300), 1);
    host_clk = 1'b0;
    cycles(3);
    check("abort_busy_last_cycle", busy, 1);
    cycles(1);
    check("abort_busy", busy, 0);
    check("abort_clk", ps2_clk, 1);
    check("abort_data", ps2_data, 1);
    check("abort_count", aborts, ab0 + 1);
    cycles(40);
    check("inhibit_hold_quiet", busy, 0);
    host_clk = 1'b1;
    wait_rx(1, 300, "rx_resend_timeout");
    wait_idle(50, "idle_resend_timeout");
    lit = {1'b1, 1'b1, 8'hF0, 1'b0};
    check("resend_f0_literal", rx_q[0], lit);
    expect_frame("resend_f0");
    check("resend_no_extra_abort", aborts, ab0 + 1);

    // Inhibit after the parity HIGH phase: stop bit completes, byte popped once.
    b   = 8'($urandom);
    ab0 = aborts;
    st0 = starts;
    write_byte(b);
    wait_rx(1, 300, "rx_late_timeout");
    host_clk = 1'b0;
    wait_idle(100, "idle_late_timeout");
    check("late_busy_len", last_busy_len, FRAME_CYC);
    check("late_no_abort", aborts, ab0);
    expect_frame("late_frame");
    cycles(40);
    host_clk = 1'b1;
    cycles(60);
    check("late_no_resend", starts, st0 + 1);
    check("late_rx_empty", rx_q.size(), 0);

    // 17 consecutive writes while inhibited: full after the 16th, 17th dropped.
    host_clk = 1'b0;
    cycles(5);
    @(negedge clk_sys);
    for (int k = 1; k <= 17; k++) begin
      byte_in = 8'($urandom);
      byte_wr = 1'b1;
      if (exp_q.size() < DEPTH) exp_q.push_back(byte_in);
      @(negedge clk_sys);
      check("full_flag", fifo_full, (exp_q.size() == DEPTH));
    end
    byte_wr  = 1'b0;
    host_clk = 1'b1;
    wait_rx(16, 3000, "rx_16_timeout");
    wait_idle(50, "idle_16_timeout");
    cycles(200);
    check("frames_16", rx_q.size(), 16);
    check("full_cleared", fifo_full, 0);
    for (int i = 0; i < 16; i++) expect_frame("frame_fifo");

    // Reset mid-LOW: lines release before the next clock edge, FIFO discarded.
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    t = 0;
    while (!(busy && !ps2_clk) && t < 300) begin
      @(negedge clk_sys);
      t++;
    end
    check("reach_low", (t < 300), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_clk", ps2_clk, 1);
    check("mid_rst_data", ps2_data, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    rx_q.delete();
    @(negedge clk_sys);
    reset = 1'b0;
    st0   = starts;
    cycles(200);
    check("post_rst_quiet", starts, st0);
    check("post_rst_rx_empty", rx_q.size(), 0);
    write_byte(8'($urandom));
    wait_rx(1, 300, "rx_post_rst_timeout");
    wait_idle(50, "idle_post_rst_timeout");
    expect_frame("post_rst_frame");
    cycles(150);
    check("post_rst_single", rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
